// File: rtl/muldiv_if.sv
// muldiv_if: handshake, operand and result bundle between the CPU control FSM
// (master) and the MULT/DIV sequencer (slave).
//   start/op/rs_val/rt_val : operation request and operands
//   hi_we/lo_we/wdata      : MTHI/MTLO writes
//   busy/done/div_zero     : status back to the control FSM
//   hi/lo                  : HI/LO registers for MFHI/MFLO
interface muldiv_if;
  logic        start;
  logic        op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_controller.sv
// muldiv_controller: sequencer for the multicycle MULT/DIV unit. Owns HI/LO and
// runs a 32-iteration signed Booth multiply or signed restoring divide.
// Ports:
//   clk     : clock, all updates on posedge
//   reset_n : synchronous active-low reset
//   bus     : muldiv_if.slave (request, MTHI/MTLO writes, status, HI/LO)
// Build option: MULDIV_DIVZERO_EXC_EN -- DIV by zero finishes one cycle after
// accept with div_zero pulsed and HI/LO untouched; otherwise it runs the full
// divide, HI gets the dividend and LO gets all ones, div_zero stays 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; MTHI/MTLO writes honoured
// S_MUL_RUN | ITER Booth add/sub + arithmetic shift steps
// S_DIV_RUN | ITER restoring shift/subtract steps on magnitudes
// S_DIV_FIX | sign correction of quotient/remainder, HI/LO written
// S_FINISH  | done pulse, HI/LO already hold the result
module muldiv_controller #(
  parameter int ITER = 32
) (
  input  logic     clk,
  input  logic     reset_n,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_RUN,
    S_DIV_RUN,
    S_DIV_FIX,
    S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [32:0]     a_q, a_d;       // Booth accumulator / divide remainder
  logic [31:0]     q_q, q_d;       // multiplier / dividend-then-quotient
  logic            q1_q, q1_d;
  logic [32:0]     m_q, m_d;       // multiplicand (sign-ext) / divisor magnitude
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            dz_q, dz_d;

  logic [31:0]     rs_abs, rt_abs;
  logic [32:0]     booth_sum;
  logic [32:0]     mul_a_nx;
  logic [31:0]     mul_q_nx;
  logic [32:0]     div_shift, div_diff;
  logic            div_qbit;
  logic            last_iter;

  assign rs_abs = bus.rs_val[31] ? (~bus.rs_val + 32'd1) : bus.rs_val;
  assign rt_abs = bus.rt_val[31] ? (~bus.rt_val + 32'd1) : bus.rt_val;

  always_comb begin
    booth_sum = a_q;
    case ({q_q[0], q1_q})
      2'b01:   booth_sum = a_q + m_q;
      2'b10:   booth_sum = a_q - m_q;
      default: booth_sum = a_q;
    endcase
  end

  // Arithmetic right shift of {A,Q,Q_1} after the Booth add/sub.
  assign mul_a_nx = {booth_sum[32], booth_sum[32:1]};
  assign mul_q_nx = {booth_sum[0], q_q[31:1]};

  // Remainder stays below 2^32, so bit 32 of the difference is a valid borrow.
  assign div_shift = {a_q[31:0], q_q[31]};
  assign div_diff  = div_shift - m_q;
  assign div_qbit  = ~div_diff[32];

  assign last_iter = (cnt_q == CW'(ITER - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start) begin
          cnt_d = '0;
          a_d   = '0;
          q1_d  = 1'b0;
          dz_d  = bus.op && (bus.rt_val == 32'd0);
          if (!bus.op) begin
            q_d     = bus.rt_val;
            m_d     = {bus.rs_val[31], bus.rs_val};
            state_d = S_MUL_RUN;
          end else begin
            q_d       = rs_abs;
            m_d       = {1'b0, rt_abs};
            neg_quo_d = bus.rs_val[31] ^ bus.rt_val[31];
            neg_rem_d = bus.rs_val[31];
            state_d   = S_DIV_RUN;
`ifdef MULDIV_DIVZERO_EXC_EN
            if (bus.rt_val == 32'd0) state_d = S_FINISH;
`endif
          end
        end
      end

      S_MUL_RUN: begin
        a_d   = mul_a_nx;
        q_d   = mul_q_nx;
        q1_d  = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          hi_d    = mul_a_nx[31:0];
          lo_d    = mul_q_nx;
          state_d = S_FINISH;
        end
      end

      S_DIV_RUN: begin
        a_d   = div_qbit ? div_diff : div_shift;
        q_d   = {q_q[30:0], div_qbit};
        cnt_d = cnt_q + 1'b1;
        if (last_iter) state_d = S_DIV_FIX;
      end

      S_DIV_FIX: begin
        // With a zero divisor the remainder ends up as |rs|, so the sign fix
        // below already restores rs_val in HI; only LO needs forcing.
        hi_d    = neg_rem_q ? (~a_q[31:0] + 32'd1) : a_q[31:0];
        lo_d    = dz_q ? 32'hFFFF_FFFF
                       : (neg_quo_q ? (~q_q + 32'd1) : q_q);
        state_d = S_FINISH;
      end

      S_FINISH: state_d = S_IDLE;

      default:  state_d = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_FINISH);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIVZERO_EXC_EN
  assign bus.div_zero = (state_q == S_FINISH) && dz_q;
`else
  assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_controller.sv
module tb_muldiv_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if mif();
  muldiv_controller #(.ITER(32)) dut (.clk(clk), .reset_n(reset_n), .bus(mif));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain signed arithmetic on the architectural operands.
  function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb2, p, q, r;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    e.dz = 1'b0;
    if (!op) begin
      p    = sa * sb2;
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.lat = 33;
    end else if (b == 32'd0) begin
`ifdef MULDIV_DIVZERO_EXC_EN
      e.hi = m_hi; e.lo = m_lo; e.dz = 1'b1; e.lat = 1;
`else
      e.hi = a; e.lo = 32'hFFFF_FFFF; e.lat = 34;
`endif
    end else begin
      q    = sa / sb2;
      r    = sa % sb2;
      e.hi = r[31:0];
      e.lo = q[31:0];
      e.lat = 34;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT signals done.
  always @(negedge clk) begin
    if (reset_n && mif.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(mif.done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", 64'(mif.hi), 64'(e.hi));
        chk("result_lo", 64'(mif.lo), 64'(e.lo));
        chk("div_zero", 64'(mif.div_zero), 64'(e.dz));
        chk("busy_with_done", 64'(mif.busy), 64'd1);
        chk("latency", 64'(cyc - accept_cyc + 1), 64'(e.lat));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_write(input logic whi, input logic wlo, input logic [31:0] d);
    mif.hi_we = whi; mif.lo_we = wlo; mif.wdata = d;
    tick();
    mif.hi_we = 1'b0; mif.lo_we = 1'b0;
    if (whi) m_hi = d;
    if (wlo) m_lo = d;
    chk("write_hi", 64'(mif.hi), 64'(m_hi));
    chk("write_lo", 64'(mif.lo), 64'(m_lo));
  endtask

  // Start one operation (optionally with a coincident write), optionally
  // poke start/hi_we while busy, and wait for the DUT to return to idle.
  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic inject, input logic wr, input logic [31:0] wd);
    exp_t e;
    int   n;
    mif.start = 1'b1; mif.op = op; mif.rs_val = a; mif.rt_val = b;
    mif.lo_we = wr; mif.wdata = wd;
    if (wr) m_lo = wd;
    e = model(op, a, b);
    sb.push_back(e);
    tick();
    accept_cyc = cyc;
    mif.start = 1'b0; mif.lo_we = 1'b0;
    mif.rs_val = $urandom; mif.rt_val = $urandom;
    n = 0;
    while (mif.busy && n < 80) begin
      if (inject && n == 5) begin
        mif.start = 1'b1; mif.hi_we = 1'b1; mif.op = $urandom_range(0, 1);
        mif.wdata = $urandom;
      end else begin
        mif.start = 1'b0; mif.hi_we = 1'b0;
      end
      tick();
      n++;
    end
    mif.start = 1'b0; mif.hi_we = 1'b0;
    chk("op_completes", 64'(mif.busy), 64'd0);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    m_hi = e.hi; m_lo = e.lo;
  endtask

  initial begin
    mif.start = 1'b0; mif.op = 1'b0; mif.rs_val = '0; mif.rt_val = '0;
    mif.hi_we = 1'b0; mif.lo_we = 1'b0; mif.wdata = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(mif.busy), 64'd0);
    chk("rst_done", 64'(mif.done), 64'd0);
    chk("rst_hi", 64'(mif.hi), 64'd0);
    chk("rst_lo", 64'(mif.lo), 64'd0);
    reset_n = 1'b1;
    tick();

    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, 32'd0);
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'd0);
    do_op(1'b0, 32'h7FFF_FFFF, 32'd2, 1'b0, 1'b0, 32'd0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'd0);
    do_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0);
    do_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    do_op(1'b0, 32'd123, 32'd456, 1'b1, 1'b0, 32'd0);
    do_op(1'b1, 32'd9, 32'd0, 1'b0, 1'b1, 32'hCAFE_0001);

    do_write(1'b0, 1'b1, 32'h0000_1234);
    do_write(1'b1, 1'b0, 32'hDEAD_BEEF);

    // Abort a MULT with reset at cycle 10: no done, everything cleared.
    mif.start = 1'b1; mif.op = 1'b0; mif.rs_val = 32'd11; mif.rt_val = 32'd13;
    tick();
    mif.start = 1'b0;
    repeat (9) tick();
    reset_n = 1'b0;
    tick();
    chk("abort_busy", 64'(mif.busy), 64'd0);
    chk("abort_done", 64'(mif.done), 64'd0);
    chk("abort_hi", 64'(mif.hi), 64'd0);
    chk("abort_lo", 64'(mif.lo), 64'd0);
    reset_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) tick();
    chk("abort_no_late_done", 64'(mif.done), 64'd0);
    do_op(1'b0, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic        op;
      logic [31:0] a, b;
      op = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($signed(b) >>> $urandom_range(0, 30));
      do_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), $urandom);
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
